// File: rtl/tx_frame_ctrl_if.sv
// tx_frame_ctrl_if: producer handshake plus shifter-control bundle for the TX
// framing controller.
//   tx_data      payload word, sampled only on a valid/ready handshake
//   tx_valid     producer has a word available
//   tx_ready     controller can accept a word (IDLE only)
//   load_enable  1-cycle strobe: shifter loads frame_data
//   shift_enable 1-cycle strobe: shifter advances one bit
//   frame_data   {stop, [parity], data, start}, bit0 = start bit
//   tx_busy      controller is in any state other than IDLE
//   frame_done   1-cycle pulse after the stop-bit period ends
// The master modport is the producer/observer side; slave is the controller.
interface tx_frame_ctrl_if #(
    parameter int DATA_BITS = 8,
    parameter int PARITY_EN = 0
);
    localparam int FRAME_BITS = DATA_BITS + 2 + PARITY_EN;

    logic [DATA_BITS-1:0]  tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  load_enable;
    logic                  shift_enable;
    logic [FRAME_BITS-1:0] frame_data;
    logic                  tx_busy;
    logic                  frame_done;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, load_enable, shift_enable, frame_data, tx_busy, frame_done
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, load_enable, shift_enable, frame_data, tx_busy, frame_done
    );
endinterface

// File: rtl/tx_frame_ctrl.sv
// tx_frame_ctrl: transmit framing/timing controller feeding an LSB-first,
// idle-high parallel-to-serial shifter. Accepts one word per handshake, builds
// {stop=1, [even parity], data, start=0} and paces the shifter's load/shift
// strobes at CLKS_PER_BIT clocks per serial bit.
//   clk    system clock, rising edge
//   n_rst  asynchronous active-low reset
//   bus    tx_frame_ctrl_if slave modport (handshake, strobes, frame, status)
// All outputs are registered; strobes are set one edge ahead so they are high
// in exactly the cycles the serial timing requires.
module tx_frame_ctrl #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 10,
    parameter int PARITY_EN    = 0
) (
    input  logic            clk,
    input  logic            n_rst,
    tx_frame_ctrl_if.slave  bus
);
    localparam int FRAME_BITS = DATA_BITS + 2 + PARITY_EN;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(FRAME_BITS);

    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CLK_PRE  = CW'(CLKS_PER_BIT - 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

    state_t                state;
    logic [CW-1:0]         clk_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [FRAME_BITS-1:0] frame_q;
    logic [FRAME_BITS-1:0] next_frame;
    logic                  load_q;
    logic                  shift_q;
    logic                  done_q;
    logic                  busy_q;
    logic                  ready_q;

    if (PARITY_EN != 0) begin : g_parity
        assign next_frame = {1'b1, ^bus.tx_data, bus.tx_data, 1'b0};
    end else begin : g_no_parity
        assign next_frame = {1'b1, bus.tx_data, 1'b0};
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            frame_q <= '1;
            load_q  <= 1'b0;
            shift_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            load_q  <= 1'b0;
            shift_q <= 1'b0;
            done_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.tx_valid && ready_q) begin
                        frame_q <= next_frame;
                        state   <= LOAD;
                        load_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                LOAD: begin
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                    state   <= SEND;
                end
                SEND: begin
                    if (clk_cnt == CLK_LAST) begin
                        clk_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                        // Look one cycle ahead: the shift strobe must be high
                        // in the cycle where clk_cnt reaches its terminal value.
                        if (clk_cnt == CLK_PRE && bit_cnt != BIT_LAST) begin
                            shift_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.frame_data   = frame_q;
    assign bus.load_enable  = load_q;
    assign bus.shift_enable = shift_q;
    assign bus.frame_done   = done_q;
    assign bus.tx_busy      = busy_q;
    assign bus.tx_ready     = ready_q;
endmodule

// File: tb/tb_tx_frame_ctrl.sv
// tb_tx_frame_ctrl: directed bench for tx_frame_ctrl. Two instances share the
// clock and reset: u_dut0 (8 data bits, 4 clocks/bit, no parity) and u_dut1
// (8 data bits, 4 clocks/bit, even parity). Expected frames and strobe cycles
// are hand-computed relative to the cycle L in which load_enable is high.
module tb_tx_frame_ctrl;
    localparam int CPB = 4;

    logic clk;
    logic n_rst;
    int   n_checks;
    int   n_pass;

    tx_frame_ctrl_if #(.DATA_BITS(8), .PARITY_EN(0)) if0 ();
    tx_frame_ctrl_if #(.DATA_BITS(8), .PARITY_EN(1)) if1 ();

    tx_frame_ctrl #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) u_dut0 (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (if0)
    );

    tx_frame_ctrl #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) u_dut1 (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (if1)
    );

    logic [1:0]  le, se, fd, busy, rdy;
    logic [31:0] fr [2];

    assign le   = {if1.load_enable,  if0.load_enable};
    assign se   = {if1.shift_enable, if0.shift_enable};
    assign fd   = {if1.frame_done,   if0.frame_done};
    assign busy = {if1.tx_busy,      if0.tx_busy};
    assign rdy  = {if1.tx_ready,     if0.tx_ready};
    assign fr[0] = 32'(if0.frame_data);
    assign fr[1] = 32'(if1.frame_data);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got running, need finished)");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int inst, input logic v, input logic [7:0] d);
        if (inst == 0) begin
            if0.tx_valid = v;
            if0.tx_data  = d;
        end else begin
            if1.tx_valid = v;
            if1.tx_data  = d;
        end
    endtask

    // Offer one word and follow its frame cycle by cycle from L.
    task automatic run_frame(input int inst, input logic [7:0] data,
                             input logic [31:0] exp_frame, input int fb,
                             input int exp_wait, input bit hold,
                             input bit disturb, input int abort_at);
        int waited;
        int errs;
        int shifts;
        int last;
        bit found;
        found  = 1'b0;
        waited = 0;
        drive(inst, 1'b1, data);
        for (int i = 1; i <= 8 && !found; i++) begin
            @(negedge clk);
            waited = i;
            if (le[inst]) found = 1'b1;
        end
        check("load_seen", 32'(found), 32'd1);
        if (!found) begin
            drive(inst, 1'b0, data);
            return;
        end
        check("load_wait", 32'(waited), 32'(exp_wait));
        check("frame_at_L", fr[inst], exp_frame);
        check("busy_at_L", 32'(busy[inst]), 32'd1);
        check("ready_at_L", 32'(rdy[inst]), 32'd0);
        if (!hold) drive(inst, 1'b0, data);
        last   = fb * CPB + 1;
        errs   = 0;
        shifts = 0;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (se[inst] !== ((c % CPB == 0) && (c <= (fb - 1) * CPB))) errs++;
            if (fd[inst] !== (c == last)) errs++;
            if (le[inst] !== 1'b0 || rdy[inst] !== 1'b0 || busy[inst] !== 1'b1) errs++;
            if (fr[inst] !== exp_frame) errs++;
            if (se[inst] === 1'b1) shifts++;
            if (c == abort_at) begin
                check("timing_pre_abort", 32'(errs), 32'd0);
                n_rst = 1'b0;
                #1;
                check("abort_busy", 32'(busy[inst]), 32'd0);
                check("abort_ready", 32'(rdy[inst]), 32'd1);
                check("abort_strobes", 32'({le[inst], se[inst], fd[inst]}), 32'd0);
                check("abort_frame", fr[inst], 32'((64'd1 << fb) - 1));
                return;
            end
            if (disturb && c < last) drive(inst, (c % 2) == 1, 8'($urandom));
        end
        if (!hold) drive(inst, 1'b0, data);
        check("strobe_timing", 32'(errs), 32'd0);
        check("shift_count", 32'(shifts), 32'(fb - 1));
    endtask

    int strobes;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_rst    = 1'b0;
        drive(0, 1'b1, 8'hA5);
        drive(1, 1'b1, 8'hA5);

        // Reset held with tx_valid asserted: no load may happen.
        strobes = 0;
        repeat (4) begin
            @(negedge clk);
            strobes += int'(le[0]) + int'(le[1]) + int'(se[0]) + int'(se[1])
                     + int'(fd[0]) + int'(fd[1]);
        end
        check("rst_strobes", 32'(strobes), 32'd0);
        check("rst_ready", 32'(rdy), 32'h3);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_frame0", fr[0], 32'h3FF);
        check("rst_frame1", fr[1], 32'h7FF);
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // Plain frame, no parity.
        run_frame(0, 8'hA5, 32'h34A, 10, 1, 1'b0, 1'b0, 0);
        repeat (3) @(negedge clk);
        check("frame_hold", fr[0], 32'h34A);
        check("idle_ready", 32'(rdy[0]), 32'd1);

        // Even parity: 0 for 8'hA5, 1 for 8'h07.
        run_frame(1, 8'hA5, 32'h54A, 11, 1, 1'b0, 1'b0, 0);
        repeat (2) @(negedge clk);
        run_frame(1, 8'h07, 32'h60E, 11, 1, 1'b0, 1'b0, 0);
        repeat (2) @(negedge clk);

        // tx_valid / tx_data disturbed during SEND must be ignored.
        run_frame(1, 8'h07, 32'h60E, 11, 1, 1'b0, 1'b1, 0);
        repeat (2) @(negedge clk);
        check("disturb_frame_hold", fr[1], 32'h60E);

        // Back-to-back with tx_valid held: second load 2 cycles after frame_done.
        run_frame(0, 8'h00, 32'h200, 10, 1, 1'b1, 1'b0, 0);
        run_frame(0, 8'hFF, 32'h3FE, 10, 2, 1'b0, 1'b0, 0);
        repeat (2) @(negedge clk);

        // Reset asserted at L+17 aborts the frame.
        run_frame(0, 8'hA5, 32'h34A, 10, 1, 1'b0, 1'b0, 17);
        strobes = 0;
        repeat (3) begin
            @(negedge clk);
            strobes += int'(le[0]) + int'(se[0]) + int'(fd[0]);
        end
        check("abort_quiet", 32'(strobes), 32'd0);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        run_frame(0, 8'h3C, 32'h278, 10, 1, 1'b0, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
